axi4_lite_slave_regfile: RTL and testbench

//  AXI4-Lite responder (slave) exposing a bank of NUM_REGS 32-bit registers.
//  It terminates the transactions issued by the AXI4-Lite master.

---
 rtl/axil_pkg.sv | 33 +++
 rtl/axil_reg_bank.sv | 39 +++
 rtl/axi4_lite_slave_regfile.sv | 180 ++++++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite register-file types: response codes, write FSM states
// and the byte-strobe merge helper.
package axil_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_A,
    WR_HAVE_D,
    WR_RESP
  } wr_state_t;

  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage with strobed write port, async read port
// and flat export of every register.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [STRB_W-1:0]        wr_strb,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NUM_REGS*32-1:0]   regs_flat
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= strb_merge(mem[wr_idx], wr_data, wr_strb);
    end
  end

  // Callers only present in-range indices; the top masks the rest.
  assign rd_data = mem[rd_idx];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[32*k +: 32] = mem[k];
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite register-file responder with independent read/write channels.
// Define AXIL_SLV_DECERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_slave_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]  reg_out,
  output logic                    reg_wr_pulse,
  output logic [IDX_W-1:0]        reg_wr_idx
);

  localparam int AIW = ADDR_WIDTH - 2;

`ifdef AXIL_SLV_DECERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  wr_state_t wr_state, wr_next;
  logic      commit;

  logic [AIW-1:0]    aw_word_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  resp_t             bresp_q;

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  resp_t             rresp_q;

  logic              pulse_q;
  logic [IDX_W-1:0]  pulse_idx_q;

  logic unused_lsb;
  assign unused_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  logic aw_hs, w_hs, ar_hs;
  assign S_AXI_BVALID  = (wr_state == WR_RESP);
  assign S_AXI_AWREADY = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_D);
  assign S_AXI_WREADY  = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_A);
  assign S_AXI_ARREADY = !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Whichever half arrived first is taken from its holding register.
  logic [AIW-1:0]    wr_word;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_in;
  assign wr_word = (wr_state == WR_HAVE_A) ? aw_word_q
                 : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = (wr_state == WR_HAVE_D) ? wdata_q : S_AXI_WDATA;
  assign wr_strb = (wr_state == WR_HAVE_D) ? wstrb_q : S_AXI_WSTRB;
  assign wr_in   = wr_word < AIW'(NUM_REGS);

  logic [AIW-1:0]    rd_word;
  logic              rd_in;
  logic [DATA_W-1:0] bank_rd;
  assign rd_word = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign rd_in   = rd_word < AIW'(NUM_REGS);

  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_next = WR_RESP;
          commit  = 1'b1;
        end else if (aw_hs) begin
          wr_next = WR_HAVE_A;
        end else if (w_hs) begin
          wr_next = WR_HAVE_D;
        end
      end
      WR_HAVE_A: begin
        if (w_hs) begin
          wr_next = WR_RESP;
          commit  = 1'b1;
        end
      end
      WR_HAVE_D: begin
        if (aw_hs) begin
          wr_next = WR_RESP;
          commit  = 1'b1;
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state    <= WR_IDLE;
      aw_word_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      pulse_q     <= 1'b0;
      pulse_idx_q <= '0;
    end else begin
      wr_state <= wr_next;
      pulse_q  <= commit && wr_in;
      if (aw_hs) aw_word_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        bresp_q     <= wr_in ? RESP_OKAY : OOR_RESP;
        pulse_idx_q <= wr_word[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in ? bank_rd : '0;
      rresp_q  <= rd_in ? RESP_OKAY : OOR_RESP;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (commit && wr_in),
    .wr_idx    (wr_word[IDX_W-1:0]),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rd_idx    (rd_word[IDX_W-1:0]),
    .rd_data   (bank_rd),
    .regs_flat (reg_out)
  );

  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign reg_wr_pulse = pulse_q;
  assign reg_wr_idx   = pulse_idx_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for axi4_lite_slave_regfile: expected B/R beats and
// write pulses are queued at issue and popped by negedge monitors.
module tb_axi4_lite_slave_regfile;

  localparam int NR = 16;

`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]      S_AXI_AWADDR;
  logic             S_AXI_AWVALID;
  logic             S_AXI_AWREADY;
  logic [31:0]      S_AXI_WDATA;
  logic [3:0]       S_AXI_WSTRB;
  logic             S_AXI_WVALID;
  logic             S_AXI_WREADY;
  logic [1:0]       S_AXI_BRESP;
  logic             S_AXI_BVALID;
  logic             S_AXI_BREADY;
  logic [31:0]      S_AXI_ARADDR;
  logic             S_AXI_ARVALID;
  logic             S_AXI_ARREADY;
  logic [31:0]      S_AXI_RDATA;
  logic [1:0]       S_AXI_RRESP;
  logic             S_AXI_RVALID;
  logic             S_AXI_RREADY;
  logic [NR*32-1:0] reg_out;
  logic             reg_wr_pulse;
  logic [3:0]       reg_wr_idx;

  axi4_lite_slave_regfile #(
    .ADDR_WIDTH (32),
    .NUM_REGS   (NR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse),
    .reg_wr_idx    (reg_wr_idx)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [NR];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [3:0]  pq [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", S_AXI_BVALID, 0);
        else chk("bresp", S_AXI_BRESP, bq.pop_front());
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", S_AXI_RVALID, 0);
        else chk("rresp_rdata", {S_AXI_RRESP, S_AXI_RDATA}, rq.pop_front());
      end
      if (reg_wr_pulse) begin
        if (pq.size() == 0) chk("pulse_unexpected", reg_wr_pulse, 0);
        else chk("pulse_idx", reg_wr_idx, pq.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input int d);
    int n;
    idle(d);
    S_AXI_AWADDR  = a;
    S_AXI_AWVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_AWREADY && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!S_AXI_AWREADY) chk("aw_timeout", S_AXI_AWREADY, 1);
    @(posedge clk);
    #1;
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] dat,
                        input logic [3:0] s, input int d);
    int n;
    idle(d);
    S_AXI_WDATA  = dat;
    S_AXI_WSTRB  = s;
    S_AXI_WVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_WREADY && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!S_AXI_WREADY) chk("w_timeout", S_AXI_WREADY, 1);
    @(posedge clk);
    #1;
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n;
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_ARREADY && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!S_AXI_ARREADY) chk("ar_timeout", S_AXI_ARREADY, 1);
    @(posedge clk);
    #1;
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] dat,
                           input logic [3:0] s, input int da, input int dw);
    logic [29:0] wi;
    wi = a[31:2];
    if (wi < NR) begin
      bq.push_back(2'b00);
      pq.push_back(wi[3:0]);
      model[wi[3:0]] = merge(model[wi[3:0]], dat, s);
    end else begin
      bq.push_back(OOR);
    end
    fork
      send_aw(a, da);
      send_w(dat, s, dw);
    join
  endtask

  function automatic logic [33:0] rd_exp(input logic [31:0] a);
    logic [29:0] ri;
    ri = a[31:2];
    if (ri < NR) return {2'b00, model[ri[3:0]]};
    return {OOR, 32'h0};
  endfunction

  task automatic axi_read(input logic [31:0] a);
    rq.push_back(rd_exp(a));
    send_ar(a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    S_AXI_AWADDR  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_ARADDR  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    for (int k = 0; k < NR; k++) model[k] = '0;

    #2;
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);
    chk("rst_rresp", S_AXI_RRESP, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_pulse", reg_wr_pulse, 0);
    chk("rst_regs", (reg_out == '0), 1);
    #20 rst = 1'b0;
    idle(1);

    // same-cycle AW and W
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("t1_bvalid", S_AXI_BVALID, 1);
    chk("t1_bresp", S_AXI_BRESP, 0);
    chk("t1_reg2", reg_out[95:64], 32'hDEADBEEF);
    chk("t1_pulse", reg_wr_pulse, 1);
    chk("t1_idx", reg_wr_idx, 2);
    idle(2);

    // W leads AW by three cycles
    axi_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
    idle(2);
    fork
      axi_write(32'h04, 32'h11223344, 4'b0101, 3, 0);
      begin
        @(posedge clk);
        repeat (2) begin
          @(negedge clk);
          chk("t2_gap_awready", S_AXI_AWREADY, 1);
          chk("t2_gap_wready", S_AXI_WREADY, 0);
        end
      end
    join
    chk("t2_reg1", reg_out[63:32], 32'hFF22FF44);
    idle(2);

    // B backpressure
    S_AXI_BREADY = 1'b0;
    axi_write(32'h0C, 32'hCAFEF00D, 4'hF, 1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_bvalid", S_AXI_BVALID, 1);
      chk("t3_bresp", S_AXI_BRESP, 0);
      chk("t3_awready", S_AXI_AWREADY, 0);
      chk("t3_wready", S_AXI_WREADY, 0);
    end
    @(posedge clk);
    #1 S_AXI_BREADY = 1'b1;
    idle(2);

    // R backpressure
    S_AXI_RREADY = 1'b0;
    axi_read(32'h08);
    repeat (4) begin
      @(negedge clk);
      chk("t4_rvalid", S_AXI_RVALID, 1);
      chk("t4_rdata", S_AXI_RDATA, 32'hDEADBEEF);
      chk("t4_arready", S_AXI_ARREADY, 0);
    end
    @(posedge clk);
    #1 S_AXI_RREADY = 1'b1;
    idle(2);

    // out-of-range read and write
    axi_read(32'h40);
    idle(2);
    axi_write(32'h44, 32'h12345678, 4'hF, 0, 0);
    idle(2);

    // read and write same register on the same edge
    rq.push_back(rd_exp(32'h08));
    fork
      axi_write(32'h08, 32'h0BADCAFE, 4'b0011, 0, 0);
      send_ar(32'h08);
    join
    idle(3);
    chk("same_edge_reg2", reg_out[95:64], 32'hDEADCAFE);

    // random mix; low address bits must be ignored
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, NR + 1) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2), $urandom_range(0, 2));
      else
        axi_read(a);
    end
    idle(3);

    // reset while a write response is pending
    S_AXI_BREADY = 1'b0;
    axi_write(32'h14, 32'h55AA55AA, 4'hF, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_bvalid", S_AXI_BVALID, 0);
    chk("t6_bresp", S_AXI_BRESP, 0);
    chk("t6_regs", (reg_out == '0), 1);
    bq.delete();
    for (int k = 0; k < NR; k++) model[k] = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("t6_awready", S_AXI_AWREADY, 1);
    chk("t6_wready", S_AXI_WREADY, 1);
    @(posedge clk);
    #1 S_AXI_BREADY = 1'b1;
    axi_read(32'h14);
    axi_write(32'h14, 32'h00000001, 4'hF, 0, 0);
    idle(3);

    n = 0;
    while ((bq.size() + rq.size() + pq.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("bq_left", bq.size(), 0);
    chk("rq_left", rq.size(), 0);
    chk("pq_left", pq.size(), 0);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("final_reg%0d", k), reg_out[32*k +: 32], model[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
